// File: rtl/core_br_pkg.sv
// Shared branch-unit constants: conditional op codes, 2-bit counter states,
// and the table index-width helper.
package core_br_pkg;

  localparam int BR_OP_BEQ  = 0;
  localparam int BR_OP_BNE  = 1;
  localparam int BR_OP_BLT  = 2;
  localparam int BR_OP_BGE  = 3;
  localparam int BR_OP_BLTU = 4;
  localparam int BR_OP_BGEU = 5;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic int idx_w(input int entries);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < entries) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/br_btb.sv
// BTB + bimodal counter table: one combinational fetch read port and one
// read/write train port. Ports: clk/rst, rd_* (fetch), tr_* (train read), wr_* (train write).
module br_btb #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 8,
  parameter int DW      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [DW-1:0]    rd_tgt,
  output logic [1:0]       rd_ctr,
  input  logic [IDX_W-1:0] tr_idx,
  output logic             tr_valid,
  output logic [TAG_W-1:0] tr_tag,
  output logic [DW-1:0]    tr_tgt,
  output logic [1:0]       tr_ctr,
  input  logic             wr_en,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [DW-1:0]    wr_tgt,
  input  logic [1:0]       wr_ctr
);
  import core_br_pkg::*;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [DW-1:0]    tgt_q   [ENTRIES];
  logic [1:0]       ctr_q   [ENTRIES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_tgt   = tgt_q[rd_idx];
  assign rd_ctr   = ctr_q[rd_idx];

  assign tr_valid = valid_q[tr_idx];
  assign tr_tag   = tag_q[tr_idx];
  assign tr_tgt   = tgt_q[tr_idx];
  assign tr_ctr   = ctr_q[tr_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_q[tr_idx] <= wr_valid;
      tag_q[tr_idx]   <= wr_tag;
      tgt_q[tr_idx]   <= wr_tgt;
      ctr_q[tr_idx]   <= wr_ctr;
    end
  end

endmodule

// File: rtl/br_predict_unit.sv
// Branch unit: fetch-side BTB/bimodal prediction, execute-side resolution,
// mispredict redirect, table training and saturating branch/miss statistics.
module br_predict_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ENTRIES     = 16,
  parameter int TAG_W       = 8,
  parameter int BR_OP_WIDTH = 3,
  parameter int STAT_W      = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_WIDTH-1:0]  if_pc_i,
  output logic                   if_pred_taken_o,
  output logic [DATA_WIDTH-1:0]  if_pred_tgt_o,
  output logic [DATA_WIDTH-1:0]  next_pc_o,
  input  logic                   ex_valid_i,
  input  logic                   ex_is_branch_i,
  input  logic                   ex_is_cond_i,
  input  logic [BR_OP_WIDTH-1:0] ex_br_op_i,
  input  logic [DATA_WIDTH-1:0]  ex_pc_i,
  input  logic [DATA_WIDTH-1:0]  ex_imm_i,
  input  logic [DATA_WIDTH-1:0]  ex_rs1_i,
  input  logic [DATA_WIDTH-1:0]  ex_rs2_i,
  input  logic [DATA_WIDTH-1:0]  ex_jump_tgt_i,
  input  logic                   ex_pred_taken_i,
  input  logic [DATA_WIDTH-1:0]  ex_pred_tgt_i,
  output logic                   redirect_o,
  input  logic                   stat_clr_i,
  output logic [STAT_W-1:0]      stat_br_o,
  output logic [STAT_W-1:0]      stat_miss_o
);
  import core_br_pkg::*;

  localparam int IDX_W  = idx_w(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic             f_valid, t_valid, t_hit;
  logic [TAG_W-1:0] f_tag, t_tag, e_tag;
  logic [DATA_WIDTH-1:0] f_tgt, t_tgt;
  logic [1:0]       f_ctr, t_ctr;
  logic             wr_en, wr_valid;
  logic [TAG_W-1:0] wr_tag;
  logic [DATA_WIDTH-1:0] wr_tgt;
  logic [1:0]       wr_ctr;

  br_btb #(
    .ENTRIES(ENTRIES),
    .IDX_W  (IDX_W),
    .TAG_W  (TAG_W),
    .DW     (DATA_WIDTH)
  ) u_btb (
    .clk     (clk_i),
    .rst     (rst_i),
    .rd_idx  (if_pc_i[IDX_W+1:2]),
    .rd_valid(f_valid),
    .rd_tag  (f_tag),
    .rd_tgt  (f_tgt),
    .rd_ctr  (f_ctr),
    .tr_idx  (ex_pc_i[IDX_W+1:2]),
    .tr_valid(t_valid),
    .tr_tag  (t_tag),
    .tr_tgt  (t_tgt),
    .tr_ctr  (t_ctr),
    .wr_en   (wr_en),
    .wr_valid(wr_valid),
    .wr_tag  (wr_tag),
    .wr_tgt  (wr_tgt),
    .wr_ctr  (wr_ctr)
  );

  assign if_pred_taken_o = f_valid
    & (f_tag == if_pc_i[TAG_HI:TAG_LO]) & f_ctr[1];
  assign if_pred_tgt_o = f_tgt;

  logic eq, lt, ltu, cmp, taken;
  logic [DATA_WIDTH-1:0] target, correct_pc;

  assign eq  = ex_rs1_i == ex_rs2_i;
  assign lt  = $signed(ex_rs1_i) < $signed(ex_rs2_i);
  assign ltu = ex_rs1_i < ex_rs2_i;

  always_comb begin
    cmp = 1'b0;
    case (ex_br_op_i)
      BR_OP_WIDTH'(BR_OP_BEQ):  cmp = eq;
      BR_OP_WIDTH'(BR_OP_BNE):  cmp = ~eq;
      BR_OP_WIDTH'(BR_OP_BLT):  cmp = lt;
      BR_OP_WIDTH'(BR_OP_BGE):  cmp = ~lt;
      BR_OP_WIDTH'(BR_OP_BLTU): cmp = ltu;
      BR_OP_WIDTH'(BR_OP_BGEU): cmp = ~ltu;
      default:                  cmp = 1'b0;
    endcase
  end

  // Non-branches are never "taken": an alias hit falls through to pc+4.
  assign taken  = ex_is_branch_i & (~ex_is_cond_i | cmp);
  assign target = ex_is_cond_i ? ex_pc_i + ex_imm_i
                               : {ex_jump_tgt_i[DATA_WIDTH-1:1], 1'b0};
  assign correct_pc = taken ? target : ex_pc_i + DATA_WIDTH'(4);

  assign redirect_o = ex_valid_i & (ex_is_branch_i
    ? ((taken != ex_pred_taken_i) | (taken & (target != ex_pred_tgt_i)))
    : ex_pred_taken_i);

  assign next_pc_o = redirect_o      ? correct_pc :
                     if_pred_taken_o ? if_pred_tgt_o :
                     if_pc_i + DATA_WIDTH'(4);

  assign e_tag = ex_pc_i[TAG_HI:TAG_LO];
  assign t_hit = t_valid & (t_tag == e_tag);

  always_comb begin
    wr_en    = 1'b0;
    wr_valid = t_valid;
    wr_tag   = t_tag;
    wr_tgt   = t_tgt;
    wr_ctr   = t_ctr;
    if (ex_valid_i & ex_is_branch_i) begin
      if (taken) begin
        wr_en    = 1'b1;
        wr_valid = 1'b1;
        wr_tag   = e_tag;
        wr_tgt   = target;
        if (!t_hit)
          wr_ctr = CTR_WT;
        else if (t_ctr != CTR_ST)
          wr_ctr = t_ctr + 2'd1;
      end else if (t_hit) begin
        wr_en = 1'b1;
        if (t_ctr != CTR_SNT)
          wr_ctr = t_ctr - 2'd1;
      end
    end else if (ex_valid_i & ex_pred_taken_i) begin
      wr_en    = 1'b1;
      wr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stat_br_o   <= '0;
      stat_miss_o <= '0;
    end else if (stat_clr_i) begin
      stat_br_o   <= '0;
      stat_miss_o <= '0;
    end else begin
      if (ex_valid_i & ex_is_branch_i & (stat_br_o != STAT_MAX))
        stat_br_o <= stat_br_o + 1'b1;
      if (redirect_o & (stat_miss_o != STAT_MAX))
        stat_miss_o <= stat_miss_o + 1'b1;
    end
  end

endmodule
